shift_add_multiplier: RTL

//  Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier. Radix-2 shift-and-add.

---
 rtl/mul_pkg.sv | 13 +
 rtl/carry_lookahead_adder.sv | 46 ++++
 rtl/shift_add_multiplier.sv | 90 +++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the multi-cycle MUL unit.
// FSM state encoding and the default operand width.
package mul_pkg;

  localparam int MUL_WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Parallel-prefix (Kogge-Stone) carry-lookahead adder, carry-in 0.
// Ports: i_add1, i_add2 (WIDTH); o_result (WIDTH+1, MSB is carry-out).
module carry_lookahead_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  output logic [WIDTH:0]   o_result
);

  localparam int LVL = $clog2(WIDTH);

  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] gfin;

  assign g0 = i_add1 & i_add2;
  assign p0 = i_add1 ^ i_add2;

  // Zero shifted in below the span: low groups keep their final g.
  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    localparam int D = 1 << l;
    logic [WIDTH-1:0] gi;
    logic [WIDTH-1:0] pi;
    logic [WIDTH-1:0] go;
    logic [WIDTH-1:0] po;
    if (l == 0) begin : g_first
      assign gi = g0;
      assign pi = p0;
    end else begin : g_next
      assign gi = g_lvl[l-1].go;
      assign pi = g_lvl[l-1].po;
    end
    assign go = gi | (pi & (gi << D));
    assign po = pi & (pi << D);
  end

  assign gfin = g_lvl[LVL-1].go;

  logic [WIDTH-1:0] last_p_unused;
  assign last_p_unused = g_lvl[LVL-1].po;

  assign o_result = {gfin[WIDTH-1],
                     p0 ^ {gfin[WIDTH-2:0], 1'b0}};

endmodule

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Ports: i_clk, i_rst_n; i_valid/o_ready/i_mcand/i_mplier in; o_valid/i_ready/o_product/o_busy out.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [2*WIDTH-1:0] o_product,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state;
  state_e             state_n;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  assign addend = acc[0] ? mcand : '0;

  carry_lookahead_adder #(
    .WIDTH (WIDTH)
  ) u_cla (
    .i_add1   (acc[2*WIDTH-1:WIDTH]),
    .i_add2   (addend),
    .o_result (sum)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_n = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (count == LAST) state_n = DONE;
      end
      DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Carry-out of the add becomes the new acc MSB on the shift.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc   <= '0;
      mcand <= '0;
      count <= '0;
    end else if (state == IDLE && i_valid) begin
      acc   <= {{WIDTH{1'b0}}, i_mplier};
      mcand <= i_mcand;
      count <= '0;
    end else if (state == RUN) begin
      acc   <= {sum, acc[WIDTH-1:1]};
      count <= count + CW'(1);
    end
  end

  assign o_product = acc;

endmodule
